// File: rtl/bip_core_run_ctl.sv
// BIP accumulator core with program-load port, run/single-step control, executed-instruction counter and clear-to-idle.
// Latency: single-cycle execute; ACC/PC/DMEM/count update on the executing edge, o_Halt the cycle after HLT.
// Backpressure: none; STEP mode holds all state until i_step, program writes outside IDLE are dropped.
module bip_core_run_ctl #(
    parameter int NBITS_O     = 11,
    parameter int NBITS_D     = 16,
    parameter int OPCODE      = 5,
    parameter int CELDAS      = 10,
    parameter int DMEM_CELDAS = 10,
    parameter int CNT_BITS    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_prog_we,
    input  logic [NBITS_O-1:0]        i_prog_addr,
    input  logic [OPCODE+NBITS_O-1:0] i_prog_data,
    input  logic                      i_start,
    input  logic                      i_step_mode,
    input  logic                      i_step,
    input  logic                      i_clear,
    output logic                      o_Halt,
    output logic [NBITS_D-1:0]        o_ACC,
    output logic [NBITS_O-1:0]        o_PC,
    output logic [CNT_BITS-1:0]       o_count,
    output logic                      o_busy
);

    localparam int IW   = OPCODE + NBITS_O;
    localparam int PA_W = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam int DA_W = (DMEM_CELDAS > 1) ? $clog2(DMEM_CELDAS) : 1;

    localparam logic [NBITS_O-1:0] PC_LAST  = NBITS_O'(CELDAS - 1);
    localparam logic [NBITS_O:0]   DMEM_LIM = (NBITS_O + 1)'(DMEM_CELDAS);

    localparam logic [OPCODE-1:0] OP_HLT  = OPCODE'(0);
    localparam logic [OPCODE-1:0] OP_STO  = OPCODE'(1);
    localparam logic [OPCODE-1:0] OP_LD   = OPCODE'(2);
    localparam logic [OPCODE-1:0] OP_LDI  = OPCODE'(3);
    localparam logic [OPCODE-1:0] OP_ADD  = OPCODE'(4);
    localparam logic [OPCODE-1:0] OP_ADDI = OPCODE'(5);
    localparam logic [OPCODE-1:0] OP_SUB  = OPCODE'(6);
    localparam logic [OPCODE-1:0] OP_SUBI = OPCODE'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    state_t                state_q, state_d;
    logic [NBITS_O-1:0]    pc_q, pc_d;
    logic [NBITS_D-1:0]    acc_q, acc_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic [IW-1:0]         pmem [CELDAS];
    logic [NBITS_D-1:0]    dmem [DMEM_CELDAS];

    logic [IW-1:0]         instr;
    logic [OPCODE-1:0]     opc;
    logic [NBITS_O-1:0]    op;
    logic [NBITS_D-1:0]    imm;
    logic                  d_addr_ok;
    logic [NBITS_D-1:0]    d_rd;
    logic                  dmem_we;
    logic                  prog_wr_ok;
    logic                  exec;

    // PC never leaves 0..CELDAS-1, so the low bits alone address the program store.
    assign instr = pmem[pc_q[PA_W-1:0]];
    assign opc   = instr[IW-1 -: OPCODE];
    assign op    = instr[NBITS_O-1:0];
    assign imm   = NBITS_D'($signed(op));

    assign d_addr_ok = ({1'b0, op} < DMEM_LIM);
    assign d_rd      = d_addr_ok ? dmem[op[DA_W-1:0]] : '0;

    assign prog_wr_ok = i_prog_we && (state_q == S_IDLE) && (i_prog_addr <= PC_LAST);
    assign exec       = !i_clear && ((state_q == S_RUN) || ((state_q == S_STEP) && i_step));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dmem_we = 1'b0;
        if (i_clear) begin
            state_d = S_IDLE;
            pc_d    = '0;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = i_step_mode ? S_STEP : S_RUN;
                    end
                end
                S_RUN, S_STEP: begin
                    if (exec) begin
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        case (opc)
                            OP_HLT:  state_d = S_HALTED;
                            OP_STO:  dmem_we = d_addr_ok;
                            OP_LD:   acc_d   = d_rd;
                            OP_LDI:  acc_d   = imm;
                            OP_ADD:  acc_d   = acc_q + d_rd;
                            OP_ADDI: acc_d   = acc_q + imm;
                            OP_SUB:  acc_d   = acc_q - d_rd;
                            OP_SUBI: acc_d   = acc_q - imm;
                            default: ;
                        endcase
                        if (opc != OP_HLT) begin
                            pc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memories are not reset: data survives i_reset and i_clear.
    always_ff @(posedge i_clk) begin
        if (prog_wr_ok) begin
            pmem[i_prog_addr[PA_W-1:0]] <= i_prog_data;
        end
        if (dmem_we) begin
            dmem[op[DA_W-1:0]] <= acc_q;
        end
    end

    assign o_Halt  = (state_q == S_HALTED);
    assign o_busy  = (state_q == S_RUN) || (state_q == S_STEP);
    assign o_ACC   = acc_q;
    assign o_PC    = pc_q;
    assign o_count = cnt_q;

endmodule
